id_ex_stage: RTL and testbench

Pipeline register between decode (ID) and execute (EX), including load-use hazard detection and a write-back-to-decode register bypass. It captures decoded operands and control each cycle. It inserts a bubble and holds the front end on a load-use dependence, and squashes on a branch or jump flush. Its ex_* outputs feed the EX stage and the forwarding unit's rs1/rs2 compare inputs.

---
 rtl/id_ex_stage_pkg.sv | 30 +++
 rtl/id_ex_stage_load_use_detect.sv | 40 ++++
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared definitions for the ID/EX pipeline register and its hazard logic.
//   Holds the width of the packed control vector, the bit positions of every
//   control field inside that vector, and the bubble control value.
//
//   Control vector layout (CTRL_W = 8):
//     [0]   reg_write
//     [1]   mem_read
//     [2]   mem_write
//     [3]   mem_to_reg
//     [4]   alu_src
//     [7:5] alu_op
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_ALU_OP     = 5;
  localparam int CTRL_ALU_OP_W   = 3;

  // A bubble carries no side effects: every control bit is low.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard detector. Flags the case where the
//   instruction in EX is a load whose destination is read by the instruction
//   in ID, so that ID must wait one cycle for the loaded value.
//
//   Ports:
//     i_ex_valid     EX holds a real instruction
//     i_ex_mem_read  EX instruction is a load
//     i_ex_rd        EX destination register
//     i_id_valid     ID holds a real instruction
//     i_id_uses_rs1  ID instruction reads rs1
//     i_id_uses_rs2  ID instruction reads rs2
//     i_id_rs1       ID source register 1
//     i_id_rs2       ID source register 2
//     o_load_use     hazard present
// -----------------------------------------------------------------------------
module load_use_detect (
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  output logic       o_load_use
);

  logic w_ex_is_load;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependence.
  assign w_ex_is_load = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0);
  assign w_rs1_hit    = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit    = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_load_use   = w_ex_is_load & i_id_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use stall generation and a
//   write-back-to-decode register bypass. Each cycle it either captures the
//   decoded instruction, or loads a bubble (flush or load-use), or clears on
//   reset. The ex_* outputs drive the EX stage and the forwarding unit.
//
//   Optional feature macro: HAZARD_STATS_EN
//     When defined, adds 32-bit stall_count / flush_count outputs.
//
//   Ports:
//     clk, reset (sync, active-low)
//     id_*        decoded instruction from ID
//     wb_*        write-back port used for the same-cycle register bypass
//     flush       EX redirected the front end
//     stall_if_id hold PC and IF/ID this cycle
//     ex_*        registered instruction for EX
//     stall_count, flush_count (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic              ex_mem_read
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);

  import id_ex_stage_pkg::*;

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_imm;
  logic [XLEN-1:0]   r_ex_rs1_data;
  logic [XLEN-1:0]   r_ex_rs2_data;
  logic [4:0]        r_ex_rs1;
  logic [4:0]        r_ex_rs2;
  logic [4:0]        r_ex_rd;
  logic [CTRL_W-1:0] r_ex_ctrl;

  logic              w_load_use;
  logic              w_bubble;
  logic [XLEN-1:0]   w_rs1_data;
  logic [XLEN-1:0]   w_rs2_data;

  // Register file is written at the end of WB, so a read in the same cycle
  // returns the stale value; take the WB result instead. x0 is never bypassed.
  function automatic logic [XLEN-1:0] bypass(
    input logic            wr_en,
    input logic [4:0]      wr_rd,
    input logic [XLEN-1:0] wr_data,
    input logic [4:0]      rd_idx,
    input logic [XLEN-1:0] rd_data
  );
    if (wr_en && (wr_rd != 5'd0) && (wr_rd == rd_idx)) return wr_data;
    return rd_data;
  endfunction

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_ex_valid),
    .i_ex_mem_read (r_ex_ctrl[CTRL_MEM_READ]),
    .i_ex_rd       (r_ex_rd),
    .i_id_valid    (id_valid),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .o_load_use    (w_load_use)
  );

  // A flush discards the ID instruction upstream, so holding it would be wrong.
  assign stall_if_id = w_load_use & ~flush;
  assign w_bubble    = flush | w_load_use;

  assign w_rs1_data = bypass(wb_reg_write, wb_rd, wb_data, id_rs1, id_rs1_data);
  assign w_rs2_data = bypass(wb_reg_write, wb_rd, wb_data, id_rs2, id_rs2_data);

  // ---- ID -> EX register boundary ----
  // Reset and bubble both produce the all-zero state.
  always_ff @(posedge clk) begin
    if (!reset || w_bubble) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_rs1      <= 5'd0;
      r_ex_rs2      <= 5'd0;
      r_ex_rd       <= 5'd0;
      r_ex_ctrl     <= CTRL_NOP;
    end else begin
      r_ex_valid    <= id_valid;
      r_ex_pc       <= id_pc;
      r_ex_imm      <= id_imm;
      r_ex_rs1_data <= w_rs1_data;
      r_ex_rs2_data <= w_rs2_data;
      // Unused source fields are zeroed so the forwarding unit cannot match them.
      r_ex_rs1      <= id_uses_rs1 ? id_rs1 : 5'd0;
      r_ex_rs2      <= id_uses_rs2 ? id_rs2 : 5'd0;
      r_ex_rd       <= id_rd;
      r_ex_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_pc        = r_ex_pc;
  assign ex_imm       = r_ex_imm;
  assign ex_rs1_data  = r_ex_rs1_data;
  assign ex_rs2_data  = r_ex_rs2_data;
  assign ex_rs1       = r_ex_rs1;
  assign ex_rs2       = r_ex_rs2;
  assign ex_rd        = r_ex_rd;
  assign ex_ctrl      = r_ex_ctrl;
  assign ex_reg_write = r_ex_ctrl[CTRL_REG_WRITE];
  assign ex_mem_read  = r_ex_ctrl[CTRL_MEM_READ];

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  // ---- hazard statistics ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (stall_if_id) r_stall_count <= r_stall_count + 32'd1;
      if (flush)       r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN = 32;

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              stall_if_id;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_reg_write, ex_mem_read;
`ifdef HAZARD_STATS_EN
  logic [31:0]       stall_count, flush_count;
`endif

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall_if_id(stall_if_id),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the instruction the spec says should be sitting in EX.
  typedef struct {
    bit              valid;
    bit [XLEN-1:0]   pc, imm, d1, d2;
    bit [4:0]        rs1, rs2, rd;
    bit [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t         m;
  int unsigned m_stalls;
  int unsigned m_flushes;

  localparam logic [CTRL_W-1:0] LOAD = (1 << CTRL_REG_WRITE) | (1 << CTRL_MEM_READ)
                                       | (1 << CTRL_MEM_TO_REG) | (1 << CTRL_ALU_SRC);
  localparam logic [CTRL_W-1:0] ALU  = (1 << CTRL_REG_WRITE) | (2 << CTRL_ALU_OP);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does the ID instruction read the register a load in EX is about to produce?
  function automatic bit model_hazard();
    bit reads;
    if (!(m.valid && m.ctrl[CTRL_MEM_READ] && m.rd != 0 && id_valid)) return 0;
    reads = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
    return reads;
  endfunction

  function automatic bit [XLEN-1:0] reg_read(input bit [4:0] idx, input bit [XLEN-1:0] rf);
    if (wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  task automatic check_ex();
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs1_data", ex_rs1_data, m.d1);
    chk("ex_rs2_data", ex_rs2_data, m.d2);
    chk("ex_rs1", ex_rs1, m.rs1);
    chk("ex_rs2", ex_rs2, m.rs2);
    chk("ex_rd", ex_rd, m.rd);
    chk("ex_ctrl", ex_ctrl, m.ctrl);
    chk("ex_reg_write", ex_reg_write, m.ctrl[CTRL_REG_WRITE]);
    chk("ex_mem_read", ex_mem_read, m.ctrl[CTRL_MEM_READ]);
`ifdef HAZARD_STATS_EN
    chk("stall_count", stall_count, m_stalls);
    chk("flush_count", flush_count, m_flushes);
`endif
  endtask

  // One clock: inputs already driven; check stall, predict, clock, check EX.
  task automatic cycle(input bit check_stall);
    ex_t nxt;
    bit  hz, stall;
    #1;
    hz    = model_hazard();
    stall = hz && !flush;
    if (check_stall) chk("stall_if_id", stall_if_id, stall);
    nxt = '{default: 0};
    if (reset && !flush && !hz) begin
      nxt.valid = id_valid;
      nxt.pc    = id_pc;
      nxt.imm   = id_imm;
      nxt.d1    = reg_read(id_rs1, id_rs1_data);
      nxt.d2    = reg_read(id_rs2, id_rs2_data);
      nxt.rs1   = id_uses_rs1 ? id_rs1 : 0;
      nxt.rs2   = id_uses_rs2 ? id_rs2 : 0;
      nxt.rd    = id_rd;
      nxt.ctrl  = id_valid ? id_ctrl : 0;
    end
    if (!reset) begin
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      m_stalls  += stall;
      m_flushes += flush;
    end
    @(posedge clk);
    m = nxt;
    #1;
    check_ex();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input bit [CTRL_W-1:0] c, input bit [4:0] rd,
                        input bit [4:0] r1, input bit u1, input bit [4:0] r2, input bit u2);
    id_valid = v; id_ctrl = c; id_rd = rd;
    id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
    id_pc = $urandom; id_imm = $urandom;
    id_rs1_data = $urandom; id_rs2_data = $urandom;
  endtask

  initial begin
    m = '{default: 0};
    m_stalls = 0; m_flushes = 0;
    reset = 1'b0; flush = 1'b0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = '0;
    set_id(1, ALU, 5'd3, 5'd1, 1, 5'd2, 1);

    // Power-up reset: register contents unknown before the first edge.
    cycle(0);
    cycle(1);
    chk("reset_stall", stall_if_id, 1'b0);
    reset = 1'b1;

    // Load-use: lw x5 then add x6,x5,x1.
    set_id(1, LOAD, 5'd5, 5'd2, 1, 5'd0, 0);
    cycle(1);
    set_id(1, ALU, 5'd6, 5'd5, 1, 5'd1, 1);
    #1 chk("lu_stall", stall_if_id, 1'b1);
    cycle(1);
    chk("lu_bubble_valid", ex_valid, 1'b0);
    chk("lu_bubble_ctrl", ex_ctrl, '0);
    cycle(1);
    chk("lu_capture_valid", ex_valid, 1'b1);
    chk("lu_capture_rs1", ex_rs1, 5'd5);

    // x0 dependence never stalls.
    set_id(1, LOAD, 5'd0, 5'd4, 1, 5'd0, 0);
    cycle(1);
    set_id(1, ALU, 5'd8, 5'd0, 1, 5'd0, 1);
    #1 chk("x0_stall", stall_if_id, 1'b0);
    cycle(1);
    chk("x0_capture_valid", ex_valid, 1'b1);

    // Unused rs2 matching a load destination.
    set_id(1, LOAD, 5'd5, 5'd2, 1, 5'd0, 0);
    cycle(1);
    set_id(1, ALU, 5'd9, 5'd3, 1, 5'd5, 0);
    #1 chk("unused_stall", stall_if_id, 1'b0);
    cycle(1);
    chk("unused_rs2", ex_rs2, 5'd0);

    // Write-back bypass.
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    set_id(1, ALU, 5'd10, 5'd7, 1, 5'd11, 1);
    id_rs1_data = '0;
    cycle(1);
    chk("bypass_rs1_data", ex_rs1_data, 32'hDEADBEEF);
    wb_reg_write = 1'b0;

    // Flush wins over a simultaneous load-use.
    set_id(1, LOAD, 5'd5, 5'd2, 1, 5'd0, 0);
    cycle(1);
    set_id(1, ALU, 5'd6, 5'd5, 1, 5'd1, 1);
    flush = 1'b1;
    #1 chk("flush_stall", stall_if_id, 1'b0);
    cycle(1);
    chk("flush_valid", ex_valid, 1'b0);
    flush = 1'b0;

    // Randomized traffic with a narrow register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0,
             ($urandom_range(0, 1) != 0) ? LOAD : CTRL_W'($urandom),
             5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), $urandom_range(0, 1) != 0,
             5'($urandom_range(0, 4)), $urandom_range(0, 1) != 0);
      wb_reg_write = $urandom_range(0, 1) != 0;
      wb_rd        = 5'($urandom_range(0, 4));
      wb_data      = $urandom;
      flush        = $urandom_range(0, 7) == 0;
      reset        = $urandom_range(0, 40) != 0;
      cycle(1);
    end
    reset = 1'b1; flush = 1'b0;

    // Reset mid-stall: load then dependent instruction, then two reset cycles.
    set_id(1, LOAD, 5'd5, 5'd2, 1, 5'd0, 0);
    cycle(1);
    set_id(1, ALU, 5'd6, 5'd5, 1, 5'd1, 1);
    reset = 1'b0;
    cycle(1);
    cycle(1);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_ctrl", ex_ctrl, '0);
    chk("rst_pc", ex_pc, '0);
    chk("rst_stall", stall_if_id, 1'b0);
`ifdef HAZARD_STATS_EN
    chk("rst_stall_count", stall_count, 32'd0);
    chk("rst_flush_count", flush_count, 32'd0);
`endif
    reset = 1'b1;
    cycle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
